// File: rtl/control_pkt_rx.sv
// Control packet receiver: pulls fixed-length packets out of a USB byte FIFO,
// validates index and XOR checksum, and commits the payload atomically into
// one of NUM_REGS control register banks.
module control_pkt_rx #(
   parameter int PAY_BYTES = 30,
   parameter int NUM_REGS  = 4
) (
   input  logic                            clk_100M,
   input  logic                            nrst,
   output logic                            usb_rd_clk,
   output logic                            usb_rd_valid,
   input  logic [7:0]                      usb_readdata,
   input  logic [7:0]                      usb_rxbytes,
   output logic [NUM_REGS*PAY_BYTES*8-1:0] cont_regs,
   output logic [NUM_REGS-1:0]             cont_update,
   output logic                            cont_en,
   output logic [15:0]                     cont_gain,
   output logic [15:0]                     cont_off,
   output logic                            pkt_err,
   output logic [7:0]                      err_cnt
);

   localparam int         PKT_BYTES = PAY_BYTES + 2;
   localparam int         BANK_W    = PAY_BYTES * 8;
   localparam logic [7:0] PKT_LEN   = 8'(PKT_BYTES);
   localparam logic [5:0] LAST_IDX  = 6'(PKT_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CHECK,
      COMMIT
   } state_e;

   state_e                            state_q, state_d;
   logic                              rd_valid_q, rd_valid_d;
   logic [5:0]                        pop_cnt_q, pop_cnt_d;
   logic                              data_vld_q;
   logic [5:0]                        rx_cnt_q;
   logic [7:0]                        idx_q;
   logic [7:0]                        xor_q;
   logic [7:0]                        chk_q;
   logic [BANK_W-1:0]                 stage_q;
   logic [NUM_REGS*BANK_W-1:0]        cont_regs_q;
   logic [NUM_REGS-1:0]               cont_update_q;
   logic                              pkt_err_q;
   logic [7:0]                        err_cnt_q;
   logic                              sample;
   logic                              pkt_ok;

   // A FIFO byte is present exactly one cycle after each pop.
   assign sample = (state_q == READ) && data_vld_q;
   assign pkt_ok = (xor_q == chk_q) && (idx_q < 8'(NUM_REGS));

   // Next-state logic: start on a full packet in the FIFO, pop exactly
   // PKT_BYTES bytes, then judge and commit the staged packet.
   always_comb begin
      state_d    = state_q;
      rd_valid_d = rd_valid_q;
      pop_cnt_d  = pop_cnt_q;
      case (state_q)
         IDLE: begin
            if (usb_rxbytes >= PKT_LEN) begin
               state_d    = READ;
               rd_valid_d = 1'b1;
               pop_cnt_d  = '0;
            end
         end
         READ: begin
            if (rd_valid_q) begin
               pop_cnt_d = pop_cnt_q + 6'd1;
               if (pop_cnt_q == LAST_IDX) begin
                  rd_valid_d = 1'b0;
               end
            end
            if (sample && (rx_cnt_q == LAST_IDX)) begin
               state_d = CHECK;
            end
         end
         CHECK:   state_d = pkt_ok ? COMMIT : IDLE;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register together with the FIFO pop control.
   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         rd_valid_q <= 1'b0;
         pop_cnt_q  <= '0;
         data_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_valid_d;
         pop_cnt_q  <= pop_cnt_d;
         data_vld_q <= rd_valid_q;
      end
   end

   // Staging: capture the index, shift payload bytes in so byte 0 lands in
   // the LSBs, keep a running XOR and hold the received checksum byte.
   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         rx_cnt_q <= '0;
         idx_q    <= '0;
         xor_q    <= '0;
         chk_q    <= '0;
         stage_q  <= '0;
      end else if (state_q == IDLE) begin
         rx_cnt_q <= '0;
         xor_q    <= '0;
      end else if (sample) begin
         rx_cnt_q <= rx_cnt_q + 6'd1;
         if (rx_cnt_q == 6'd0) begin
            idx_q <= usb_readdata;
            xor_q <= usb_readdata;
         end else if (rx_cnt_q != LAST_IDX) begin
            stage_q <= {usb_readdata, stage_q[BANK_W-1:8]};
            xor_q   <= xor_q ^ usb_readdata;
         end else begin
            chk_q <= usb_readdata;
         end
      end
   end

   // Committed banks, update/error pulses and the saturating error counter.
   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         cont_regs_q   <= '0;
         cont_update_q <= '0;
         pkt_err_q     <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         cont_update_q <= '0;
         pkt_err_q     <= 1'b0;
         if ((state_q == CHECK) && !pkt_ok) begin
            pkt_err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
               err_cnt_q <= err_cnt_q + 8'd1;
            end
         end
         if (state_q == COMMIT) begin
            for (int n = 0; n < NUM_REGS; n++) begin
               if (idx_q == 8'(n)) begin
                  cont_regs_q[n*BANK_W +: BANK_W] <= stage_q;
                  cont_update_q[n]                <= 1'b1;
               end
            end
         end
      end
   end

   assign usb_rd_clk   = clk_100M;
   assign usb_rd_valid = rd_valid_q;
   assign cont_regs    = cont_regs_q;
   assign cont_update  = cont_update_q;
   assign pkt_err      = pkt_err_q;
   assign err_cnt      = err_cnt_q;
   assign cont_en      = cont_regs_q[0];
   assign cont_gain    = cont_regs_q[23:8];
   assign cont_off     = cont_regs_q[39:24];

endmodule

// File: tb/tb_control_pkt_rx.sv
// Testbench for control_pkt_rx: a byte FIFO model feeds packets, a bank-level
// reference model predicts commits and rejections.
module tb_control_pkt_rx;

   localparam int PAY_BYTES = 30;
   localparam int NUM_REGS  = 4;
   localparam int PKT_BYTES = PAY_BYTES + 2;
   localparam int BANK_W    = PAY_BYTES * 8;
   localparam int REGS_W    = NUM_REGS * BANK_W;

   typedef logic [7:0] pay_t [PAY_BYTES];

   typedef struct {
      int                  hi;
      int                  rises;
      int                  pops;
      int                  upd_n;
      logic [NUM_REGS-1:0] upd_val;
      int                  lat;
      int                  gap;
      int                  err_n;
      bit                  timeout;
   } obs_t;

   logic                clk_100M = 1'b0;
   logic                nrst = 1'b0;
   logic                usb_rd_clk;
   logic                usb_rd_valid;
   logic [7:0]          usb_readdata = 8'h00;
   logic [7:0]          usb_rxbytes;
   logic [REGS_W-1:0]   cont_regs;
   logic [NUM_REGS-1:0] cont_update;
   logic                cont_en;
   logic [15:0]         cont_gain;
   logic [15:0]         cont_off;
   logic                pkt_err;
   logic [7:0]          err_cnt;

   int checks = 0;
   int failures = 0;

   control_pkt_rx #(.PAY_BYTES(PAY_BYTES), .NUM_REGS(NUM_REGS)) dut (
      .clk_100M    (clk_100M),
      .nrst        (nrst),
      .usb_rd_clk  (usb_rd_clk),
      .usb_rd_valid(usb_rd_valid),
      .usb_readdata(usb_readdata),
      .usb_rxbytes (usb_rxbytes),
      .cont_regs   (cont_regs),
      .cont_update (cont_update),
      .cont_en     (cont_en),
      .cont_gain   (cont_gain),
      .cont_off    (cont_off),
      .pkt_err     (pkt_err),
      .err_cnt     (err_cnt)
   );

   always #5 clk_100M = ~clk_100M;

   // FIFO model: tasks write at wr_ptr, pops advance rd_ptr, data appears
   // in the cycle after the pop.
   logic [7:0] mem [16384];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         pop_cnt = 0;
   logic       flush_req = 1'b0;

   assign usb_rxbytes = ((wr_ptr - rd_ptr) > 255) ? 8'hFF : 8'(wr_ptr - rd_ptr);

   // Pop one byte per cycle of read request; a flush discards the contents.
   always @(posedge clk_100M) begin
      if (flush_req) begin
         rd_ptr <= wr_ptr;
      end else if (usb_rd_valid) begin
         usb_readdata <= mem[rd_ptr[13:0]];
         rd_ptr       <= rd_ptr + 1;
         pop_cnt      <= pop_cnt + 1;
      end
   end

   // Event monitor: logs read-request starts, update pulses and error pulses.
   int                  cyc = 0;
   int                  hi_total = 0;
   int                  err_total = 0;
   logic                prev_rd = 1'b0;
   int                  rise_q[$];
   int                  upd_cyc_q[$];
   logic [NUM_REGS-1:0] upd_val_q[$];

   always @(negedge clk_100M) begin
      cyc <= cyc + 1;
      if (usb_rd_valid) begin
         hi_total <= hi_total + 1;
         if (!prev_rd) rise_q.push_back(cyc);
      end
      prev_rd <= usb_rd_valid;
      if (|cont_update) begin
         upd_cyc_q.push_back(cyc);
         upd_val_q.push_back(cont_update);
      end
      if (pkt_err) err_total <= err_total + 1;
   end

   // Reference model: bank contents as byte arrays plus the error count.
   logic [7:0] mbank [NUM_REGS][PAY_BYTES];
   int         merr = 0;

   task automatic model_reset();
      for (int b = 0; b < NUM_REGS; b++)
         for (int i = 0; i < PAY_BYTES; i++) mbank[b][i] = 8'h00;
      merr = 0;
   endtask

   function automatic logic [REGS_W-1:0] model_regs();
      logic [REGS_W-1:0] r;
      r = '0;
      for (int b = 0; b < NUM_REGS; b++)
         for (int i = 0; i < PAY_BYTES; i++) r[(b*PAY_BYTES+i)*8 +: 8] = mbank[b][i];
      return r;
   endfunction

   function automatic logic [BANK_W-1:0] bank_of(input logic [REGS_W-1:0] v, input int b);
      return v[b*BANK_W +: BANK_W];
   endfunction

   function automatic int first_diff_bank(input logic [REGS_W-1:0] a, input logic [REGS_W-1:0] e);
      for (int b = 0; b < NUM_REGS; b++)
         if (a[b*BANK_W +: BANK_W] !== e[b*BANK_W +: BANK_W]) return b;
      return 0;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      mem[wr_ptr[13:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   // Queue one packet (checksum optionally corrupted by mask) and apply the
   // packet's effect to the reference model.
   task automatic send_packet(input logic [7:0] idx, input pay_t pay, input logic [7:0] mask,
                              output bit exp_ok);
      logic [7:0] x;
      logic [7:0] sent_chk;
      x = idx;
      for (int i = 0; i < PAY_BYTES; i++) x = x ^ pay[i];
      sent_chk = x ^ mask;
      push_byte(idx);
      for (int i = 0; i < PAY_BYTES; i++) push_byte(pay[i]);
      push_byte(sent_chk);
      exp_ok = (sent_chk == x) && (int'(idx) < NUM_REGS);
      if (exp_ok) begin
         for (int i = 0; i < PAY_BYTES; i++) mbank[idx][i] = pay[i];
      end else if (merr < 255) begin
         merr = merr + 1;
      end
   endtask

   // Wait (bounded) for n_events commit/reject pulses and summarise activity.
   task automatic observe(input int n_events, output obs_t o);
      int h0, r0, u0, e0, p0;
      h0 = hi_total; r0 = rise_q.size(); u0 = upd_cyc_q.size(); e0 = err_total; p0 = pop_cnt;
      o.timeout = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_100M); #1;
         if ((upd_cyc_q.size() - u0) + (err_total - e0) >= n_events) begin
            o.timeout = 1'b0;
            break;
         end
      end
      repeat (4) @(negedge clk_100M);
      #1;
      o.hi      = hi_total - h0;
      o.rises   = rise_q.size() - r0;
      o.pops    = pop_cnt - p0;
      o.upd_n   = upd_cyc_q.size() - u0;
      o.err_n   = err_total - e0;
      o.upd_val = '0;
      for (int k = u0; k < upd_cyc_q.size(); k++) o.upd_val = o.upd_val | upd_val_q[k];
      o.lat = (o.upd_n > 0 && o.rises > 0) ? upd_cyc_q[u0] - rise_q[r0] : -1;
      o.gap = (o.upd_n > 0 && o.rises > 1) ? rise_q[r0+1] - upd_cyc_q[u0] : -1;
   endtask

   task automatic flush_fifo();
      @(negedge clk_100M); flush_req = 1'b1;
      @(negedge clk_100M); flush_req = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_100M);
      #1;
      checks++;
      if (usb_rd_valid !== 1'b0 || cont_update !== '0 || pkt_err !== 1'b0 || err_cnt !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: got rd_valid=%b upd=%b err=%b cnt=%0d expected 0 0 0 0",
                  usb_rd_valid, cont_update, pkt_err, err_cnt);
      end
      checks++;
      if (cont_regs !== '0) begin
         failures++;
         $display("[TB] FAIL reset_banks: got %h expected 0", bank_of(cont_regs, first_diff_bank(cont_regs, '0)));
      end
      checks++;
      if (usb_rd_clk !== clk_100M) begin
         failures++;
         $display("[TB] FAIL rd_clk: got %b expected %b", usb_rd_clk, clk_100M);
      end
      model_reset();
      nrst = 1'b1;
   endtask

   task automatic test_basic();
      pay_t p;
      bit   ok;
      obs_t o;
      for (int i = 0; i < PAY_BYTES; i++) p[i] = 8'($urandom);
      p[0] = 8'h01; p[1] = 8'h34; p[2] = 8'h12; p[3] = 8'hCD; p[4] = 8'hAB;
      send_packet(8'd0, p, 8'h00, ok);
      observe(1, o);
      checks++;
      if (o.timeout || o.hi !== PKT_BYTES || o.rises !== 1 || o.pops !== PKT_BYTES) begin
         failures++;
         $display("[TB] FAIL basic_reads: got timeout=%0d hi=%0d runs=%0d pops=%0d expected 0 %0d 1 %0d",
                  o.timeout, o.hi, o.rises, o.pops, PKT_BYTES, PKT_BYTES);
      end
      checks++;
      if (o.upd_n !== 1 || o.upd_val !== 4'b0001 || o.lat !== PKT_BYTES + 3 || o.err_n !== 0) begin
         failures++;
         $display("[TB] FAIL basic_update: got n=%0d val=%b lat=%0d errs=%0d expected 1 0001 %0d 0",
                  o.upd_n, o.upd_val, o.lat, o.err_n, PKT_BYTES + 3);
      end
      checks++;
      if (cont_en !== 1'b1 || cont_gain !== 16'h1234 || cont_off !== 16'hABCD) begin
         failures++;
         $display("[TB] FAIL basic_fields: got en=%b gain=%h off=%h expected 1 1234 abcd", cont_en, cont_gain, cont_off);
      end
      checks++;
      if (cont_regs !== model_regs()) begin
         failures++;
         $display("[TB] FAIL basic_banks: got %h expected %h",
                  bank_of(cont_regs, first_diff_bank(cont_regs, model_regs())),
                  bank_of(model_regs(), first_diff_bank(cont_regs, model_regs())));
      end
   endtask

   task automatic test_bank_select();
      pay_t p;
      bit   ok;
      obs_t o;
      for (int i = 0; i < PAY_BYTES; i++) p[i] = 8'h5A;
      send_packet(8'd2, p, 8'h00, ok);
      observe(1, o);
      checks++;
      if (o.timeout || o.upd_n !== 1 || o.upd_val !== 4'b0100 || o.lat !== PKT_BYTES + 3) begin
         failures++;
         $display("[TB] FAIL bank2_update: got timeout=%0d n=%0d val=%b lat=%0d expected 0 1 0100 %0d",
                  o.timeout, o.upd_n, o.upd_val, o.lat, PKT_BYTES + 3);
      end
      checks++;
      if (cont_regs !== model_regs()) begin
         failures++;
         $display("[TB] FAIL bank2_banks: got %h expected %h",
                  bank_of(cont_regs, first_diff_bank(cont_regs, model_regs())),
                  bank_of(model_regs(), first_diff_bank(cont_regs, model_regs())));
      end
      checks++;
      if (cont_gain !== {mbank[0][2], mbank[0][1]} || cont_off !== {mbank[0][4], mbank[0][3]}) begin
         failures++;
         $display("[TB] FAIL bank2_bank0_fields: got gain=%h off=%h expected %h %h",
                  cont_gain, cont_off, {mbank[0][2], mbank[0][1]}, {mbank[0][4], mbank[0][3]});
      end
   endtask

   task automatic test_bad_packets();
      pay_t p;
      bit   ok;
      obs_t o;
      for (int i = 0; i < PAY_BYTES; i++) p[i] = 8'($urandom);
      send_packet(8'd0, p, 8'h01, ok);
      observe(1, o);
      checks++;
      if (o.timeout || o.err_n !== 1 || o.upd_n !== 0 || err_cnt !== 8'(merr)) begin
         failures++;
         $display("[TB] FAIL bad_checksum: got timeout=%0d errs=%0d upd=%0d cnt=%0d expected 0 1 0 %0d",
                  o.timeout, o.err_n, o.upd_n, err_cnt, merr);
      end
      send_packet(8'd7, p, 8'h00, ok);
      observe(1, o);
      checks++;
      if (o.timeout || o.err_n !== 1 || o.upd_n !== 0 || err_cnt !== 8'(merr)) begin
         failures++;
         $display("[TB] FAIL bad_index: got timeout=%0d errs=%0d upd=%0d cnt=%0d expected 0 1 0 %0d",
                  o.timeout, o.err_n, o.upd_n, err_cnt, merr);
      end
      checks++;
      if (cont_regs !== model_regs()) begin
         failures++;
         $display("[TB] FAIL bad_banks: got %h expected %h",
                  bank_of(cont_regs, first_diff_bank(cont_regs, model_regs())),
                  bank_of(model_regs(), first_diff_bank(cont_regs, model_regs())));
      end
   endtask

   task automatic test_random();
      pay_t       p;
      bit         ok;
      obs_t       o;
      logic [7:0] idx;
      logic [7:0] mask;
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < PAY_BYTES; i++) p[i] = 8'($urandom);
         idx  = 8'($urandom_range(0, NUM_REGS + 1));
         mask = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         send_packet(idx, p, mask, ok);
         observe(1, o);
         checks++;
         if (o.timeout || (ok && (o.upd_n !== 1 || o.upd_val !== NUM_REGS'(1 << idx) || o.lat !== PKT_BYTES + 3
                                  || o.err_n !== 0))
                       || (!ok && (o.err_n !== 1 || o.upd_n !== 0))) begin
            failures++;
            $display("[TB] FAIL random_pkt%0d: got timeout=%0d upd=%0d val=%b lat=%0d errs=%0d expected valid=%0d idx=%0d",
                     n, o.timeout, o.upd_n, o.upd_val, o.lat, o.err_n, ok, idx);
         end
         checks++;
         if (cont_regs !== model_regs() || err_cnt !== 8'(merr)) begin
            failures++;
            $display("[TB] FAIL random_state%0d: got cnt=%0d bank %h expected cnt=%0d bank %h", n, err_cnt,
                     bank_of(cont_regs, first_diff_bank(cont_regs, model_regs())), merr,
                     bank_of(model_regs(), first_diff_bank(cont_regs, model_regs())));
         end
      end
   endtask

   task automatic test_saturation();
      pay_t p;
      bit   ok;
      obs_t o;
      int   bad_pulses;
      bad_pulses = 0;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < PAY_BYTES; i++) p[i] = 8'($urandom);
         send_packet(8'($urandom_range(0, NUM_REGS - 1)), p, 8'h80, ok);
         observe(1, o);
         checks++;
         if (o.timeout || o.err_n !== 1 || o.upd_n !== 0) begin
            failures++;
            bad_pulses++;
            if (bad_pulses < 5)
               $display("[TB] FAIL sat_pulse%0d: got timeout=%0d errs=%0d upd=%0d expected 0 1 0",
                        n, o.timeout, o.err_n, o.upd_n);
         end
      end
      checks++;
      if (err_cnt !== 8'(merr) || err_cnt !== 8'hFF) begin
         failures++;
         $display("[TB] FAIL sat_count: got %0d expected %0d", err_cnt, merr);
      end
      checks++;
      if (cont_regs !== model_regs()) begin
         failures++;
         $display("[TB] FAIL sat_banks: got %h expected %h",
                  bank_of(cont_regs, first_diff_bank(cont_regs, model_regs())),
                  bank_of(model_regs(), first_diff_bank(cont_regs, model_regs())));
      end
   endtask

   task automatic test_reset_midpacket();
      pay_t p;
      bit   ok;
      obs_t o;
      int   r0, u0;
      bit   started;
      for (int i = 0; i < PAY_BYTES; i++) p[i] = 8'($urandom);
      r0 = rise_q.size();
      u0 = upd_cyc_q.size();
      send_packet(8'd1, p, 8'h00, ok);
      started = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_100M); #1;
         if (rise_q.size() > r0) begin
            started = 1'b1;
            break;
         end
      end
      checks++;
      if (!started) begin
         failures++;
         $display("[TB] FAIL midrst_start: got no read request expected one within 50 cycles");
      end
      repeat (10) @(posedge clk_100M);
      #1 nrst = 1'b0;
      #1;
      model_reset();
      checks++;
      if (usb_rd_valid !== 1'b0 || cont_update !== '0 || pkt_err !== 1'b0 || err_cnt !== 8'h00) begin
         failures++;
         $display("[TB] FAIL midrst_ctrl: got rd_valid=%b upd=%b err=%b cnt=%0d expected 0 0 0 0",
                  usb_rd_valid, cont_update, pkt_err, err_cnt);
      end
      checks++;
      if (cont_regs !== model_regs()) begin
         failures++;
         $display("[TB] FAIL midrst_banks: got %h expected 0",
                  bank_of(cont_regs, first_diff_bank(cont_regs, model_regs())));
      end
      flush_fifo();
      repeat (2) @(negedge clk_100M);
      nrst = 1'b1;
      repeat (3) @(negedge clk_100M);
      #1;
      checks++;
      if (upd_cyc_q.size() !== u0) begin
         failures++;
         $display("[TB] FAIL midrst_no_commit: got %0d updates expected 0", upd_cyc_q.size() - u0);
      end
      for (int i = 0; i < PAY_BYTES; i++) p[i] = 8'($urandom);
      send_packet(8'd1, p, 8'h00, ok);
      observe(1, o);
      checks++;
      if (o.timeout || o.upd_n !== 1 || o.upd_val !== 4'b0010 || o.lat !== PKT_BYTES + 3 || o.pops !== PKT_BYTES) begin
         failures++;
         $display("[TB] FAIL midrst_recover: got timeout=%0d n=%0d val=%b lat=%0d pops=%0d expected 0 1 0010 %0d %0d",
                  o.timeout, o.upd_n, o.upd_val, o.lat, o.pops, PKT_BYTES + 3, PKT_BYTES);
      end
      checks++;
      if (cont_regs !== model_regs()) begin
         failures++;
         $display("[TB] FAIL midrst_banks_after: got %h expected %h",
                  bank_of(cont_regs, first_diff_bank(cont_regs, model_regs())),
                  bank_of(model_regs(), first_diff_bank(cont_regs, model_regs())));
      end
   endtask

   task automatic test_back_to_back();
      pay_t p;
      bit   ok;
      obs_t o;
      int   r0, h0;
      r0 = rise_q.size();
      h0 = hi_total;
      for (int i = 0; i < PKT_BYTES - 1; i++) push_byte(8'($urandom));
      repeat (100) @(negedge clk_100M);
      #1;
      checks++;
      if (rise_q.size() !== r0 || hi_total !== h0) begin
         failures++;
         $display("[TB] FAIL threshold_31: got %0d read cycles expected 0", hi_total - h0);
      end
      flush_fifo();
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < PAY_BYTES; i++) p[i] = 8'($urandom);
         send_packet(8'($urandom_range(0, NUM_REGS - 1)), p, 8'h00, ok);
      end
      observe(2, o);
      checks++;
      if (o.timeout || o.pops !== 2 * PKT_BYTES || o.hi !== 2 * PKT_BYTES || o.rises !== 2) begin
         failures++;
         $display("[TB] FAIL b2b_reads: got timeout=%0d pops=%0d hi=%0d runs=%0d expected 0 %0d %0d 2",
                  o.timeout, o.pops, o.hi, o.rises, 2 * PKT_BYTES, 2 * PKT_BYTES);
      end
      checks++;
      if (o.upd_n !== 2 || o.gap !== 1 || o.lat !== PKT_BYTES + 3) begin
         failures++;
         $display("[TB] FAIL b2b_commits: got n=%0d gap=%0d lat=%0d expected 2 1 %0d",
                  o.upd_n, o.gap, o.lat, PKT_BYTES + 3);
      end
      checks++;
      if (cont_regs !== model_regs()) begin
         failures++;
         $display("[TB] FAIL b2b_banks: got %h expected %h",
                  bank_of(cont_regs, first_diff_bank(cont_regs, model_regs())),
                  bank_of(model_regs(), first_diff_bank(cont_regs, model_regs())));
      end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      test_reset();
      test_basic();
      test_bank_select();
      test_bad_packets();
      test_random();
      test_saturation();
      test_reset_midpacket();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
